// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port between instruction fetch (I) and load/store (D).
// Latency: grant registered one cycle after a request is seen in IDLE, ack two cycles later minimum (IDLE->BUSY->ACK).
// Backpressure: requests are held until their ack; mem_ready low stretches BUSY indefinitely; if_stall/mem_stall report waiting.
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   i_req/i_addr          fetch request and address (held until i_ack)
//   i_ack/i_rdata         one-cycle fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request: store when d_we=1, load otherwise
//   d_ack/d_rdata         one-cycle data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command, held while BUSY
//   mem_rdata/mem_ready   memory read data and completion strobe (only looked at in BUSY)
//   if_stall/mem_stall    combinational stall indications to the pipeline
//   conflict_cnt/starve_cnt  performance counters, present only when ARB_PERF_CNT_EN is defined
//
// Build option: define ARB_PERF_CNT_EN to add the conflict_cnt and starve_cnt counters.

module mem_port_arbiter #(
  parameter int MAX_STREAK = 3,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          i_req,
  input  logic [DW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,

  output logic          if_stall,
  output logic          mem_stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   conflict_cnt,
  output logic [15:0]   starve_cnt
`endif
);

  // Streak counter only needs to reach MAX_STREAK.
  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e        state_q;
  logic          owner_d_q;   // 1: current access belongs to the D side
  logic [SW-1:0] streak_q;

  logic          mem_en_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // Arbitration decision, only acted upon in IDLE.
  logic          both_req;
  logic          force_i;
  logic          grant_i;
  logic          grant_d;
  logic [SW-1:0] streak_d;

  always_comb begin
    both_req = i_req & d_req;
    // D normally wins a conflict; once it has won MAX_STREAK times in a row
    // while a fetch was waiting, the fetch is forced through.
    force_i  = both_req & (streak_q == STREAK_MAX);
    grant_d  = d_req & ~force_i;
    grant_i  = i_req & ~grant_d;

    streak_d = streak_q;
    if (grant_d) begin
      if (i_req) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
      end else begin
        // A D grant with no fetch waiting is not starving anyone.
        streak_d = '0;
      end
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  // Main sequencer: IDLE -> BUSY (until mem_ready) -> ACK (one cycle) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_d || grant_i) begin
            state_q   <= ST_BUSY;
            owner_d_q <= grant_d;
            streak_q  <= streak_d;
            mem_en_q  <= 1'b1;
            if (grant_d) begin
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_we_q    <= d_we;
            end else begin
              // Fetches never write; write data is left as it was.
              mem_addr_q  <= i_addr;
              mem_we_q    <= 1'b0;
            end
          end
        end

        ST_BUSY: begin
          // Command lines stay frozen until the memory completes.
          if (mem_ready) begin
            state_q  <= ST_ACK;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_d_q) begin
              d_ack_q <= 1'b1;
              // A store returns no data; keep the previous load result.
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end
        end

        ST_ACK: begin
          // Single ack cycle; the requester gets one cycle to drop or
          // change its request before IDLE samples it again.
          state_q <= ST_IDLE;
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          i_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] conflict_q;
  logic [15:0] starve_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q <= '0;
      starve_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      // With both requests up a grant is always made in IDLE.
      if (both_req && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
      if (grant_i && force_i && (starve_q != 16'hFFFF)) begin
        starve_q <= starve_q + 16'd1;
      end
    end
  end

  assign conflict_cnt = conflict_q;
  assign starve_cnt   = starve_q;
`endif

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls are combinational so the pipeline sees release in the ack cycle.
  assign if_stall  = i_req & ~i_ack_q;
  assign mem_stall = d_req & ~d_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit unified memory port between the instruction-fetch stage (I side) and the load/store stage (D side) of the 16-bit pipelined RISC core.
- Sequences each access, drives the memory address, write-data and enable lines, and returns read data with a one-cycle acknowledge pulse.
- Data accesses win conflicts; a streak limit prevents fetch starvation.

Parameters:
- MAX_STREAK, 3: maximum consecutive D grants while i_req is pending before I is forced.
- DW, 16: data and address width. Fixed at 16; not intended to be overridden.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request; held until i_ack
- i_addr  input  16  fetch address; stable while i_req
- i_ack  output  1  one-cycle pulse; fetch complete
- i_rdata  output  16  fetched word; valid while i_ack=1
- d_req  input  1  data request; held until d_ack
- d_we  input  1  1=store, 0=load
- d_addr  input  16  data address
- d_wdata  input  16  store data
- d_ack  output  1  one-cycle pulse; data access complete
- d_rdata  output  16  load data; valid while d_ack=1
- mem_en  output  1  memory access active
- mem_we  output  1  memory write strobe, qualified by mem_en
- mem_addr  output  16  memory address
- mem_wdata  output  16  memory write data
- mem_rdata  input  16  memory read data; valid with mem_ready
- mem_ready  input  1  memory completes the current access this cycle
- if_stall  output  1  combinational: i_req & ~i_ack
- mem_stall  output  1  combinational: d_req & ~d_ack

Behaviour:
- Clocking: single clock clk. Synchronous, active-high reset.
- Reset values: state=IDLE. mem_en, mem_we, i_ack and d_ack are 0. mem_addr, mem_wdata, i_rdata and d_rdata are 16'h0000. Streak counter is 0.
- State IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D, unless streak==MAX_STREAK, in which case grant I.
  - On grant, register the winner's address into mem_addr. For D, also register d_wdata and d_we. For I, mem_we=0.
  - Set mem_en=1, record the owner and go to BUSY.
- Streak counter:
  - A D grant made while i_req=1 increments the counter, saturating at MAX_STREAK.
  - Any I grant clears it.
  - A D grant made while i_req=0 clears it.
- State BUSY:
  - mem_en, mem_we, mem_addr and mem_wdata are held constant.
  - Stay in BUSY while mem_ready=0. There is no wait-state limit.
  - On a cycle with mem_ready=1:
    - Capture mem_rdata into the owner's rdata register (for loads and fetches; for stores rdata is unchanged).
    - Clear mem_en and mem_we; next state is ACK.
    - The owner's ack register is set, so ack is high during the ACK cycle.
- State ACK:
  - Exactly one cycle; no grant is made. Owner's ack=1.
  - Next state is IDLE, with ack back to 0.
  - The requester may drop req or present a new request in the cycle after ack.
- Latency and throughput:
  - Request seen in IDLE at cycle N: mem_en is high from N+1.
  - mem_ready at N+1 gives ack at N+2; minimum latency is 2 cycles.
  - Peak throughput is one access per 3 cycles.
- Request changes: an i_req/d_req deassertion while BUSY does not abort the access. The ack is still issued and the requester ignores it.
- Ignored input: mem_ready is ignored in IDLE and ACK.
- Ack exclusivity: i_ack and d_ack are never high together.
- Reset mid-transaction: the access is abandoned, all outputs take reset values next cycle, and no ack is issued.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt [15:0], a saturating count of IDLE cycles in which i_req and d_req were both high and a grant was made.
  - Adds output starve_cnt [15:0], a saturating count of forced-I grants.
  - Both counters are cleared by reset.
- Undefined: both ports and both counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Lone fetch: i_req=1, i_addr=16'h0040, mem_ready=1 immediately, mem_rdata=16'hA5A5. Expect mem_en at cycle 1 with mem_addr=16'h0040 and mem_we=0. Expect i_ack=1 and i_rdata=16'hA5A5 at cycle 2 only. d_ack stays 0.
- Store with wait states: d_req=1, d_we=1, d_addr=16'h1234, d_wdata=16'hBEEF, mem_ready low for 3 cycles. Expect mem_we, mem_addr and mem_wdata constant for 4 BUSY cycles, then d_ack for one cycle.
- Simultaneous requests, MAX_STREAK=3: i_req and d_req held high with back-to-back D requests. Expect grant order D,D,D,I,D,D,D,I. In the ARB_PERF_CNT_EN build, starve_cnt=2 after 8 grants.
- Back-to-back fetch: after i_ack, i_req stays high with a new i_addr=16'h0041. Expect the next mem_en 2 cycles after the previous ack cycle (through IDLE), giving 3-cycle spacing between acks.
- Reset mid-op: assert reset while BUSY with mem_ready=0. Expect mem_en=0, all acks 0, rdata=16'h0000 and streak=0 next cycle. Expect no ack after reset releases unless req is re-sampled in IDLE.
- Stall outputs: with d_req high and BUSY for 2 wait states, mem_stall=1 every cycle until the d_ack cycle, then 0 in that cycle. if_stall mirrors the same rule on the I side.
